usr_seq: RTL and testbench

Sequencer for the universal shift register: accepts transmit/receive commands over a valid/ready handshake and drives the register's mode select and parallel input to load, shift and capture a WIDTH-bit word. Sits between a host-side command source and one shift register instance, whose serial pins connect directly to the link. It paces shifting with an external bit-enable and returns the final register contents over a valid/ready response channel.

---
 rtl/usr_seq_if.sv | 22 ++
 rtl/usr_seq.sv | 109 ++++++++++
 tb/tb_usr_seq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usr_seq_if.sv
// Command/response handshake bundle between a host command source and the
// shift-register sequencer.
interface usr_seq_if #(parameter int WIDTH = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic             cmd_dir;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/usr_seq.sv
// Sequencer for a universal shift register: load/shift/capture a WIDTH-bit
// word per command, paced by shift_en, result returned on a response channel.
module usr_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  usr_seq_if.slave         bus,
  input  logic             shift_en,
  input  logic             abort,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_pi,
  input  logic [WIDTH-1:0] usr_po,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] CAPT  = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             accept;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dir_d      = dir_q;
    data_d     = data_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d  = bus.cmd_op;
        dir_d = bus.cmd_dir;
        cnt_d = '0;
        // RX leaves the previous TX word on usr_pi
        if (!bus.cmd_op) data_d = bus.cmd_data;
        state_d = bus.cmd_op ? SHIFT : LOAD;
      end
      LOAD:  state_d = SHIFT;
      SHIFT: if (shift_en && cnt_q != FULL) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = CAPT;
      end
      CAPT: begin
        rsp_data_d = usr_po;
        state_d    = RESP;
      end
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d    = IDLE;
      rsp_data_d = rsp_data_q;
    end
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      dir_q       <= 1'b0;
      data_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    usr_s = 2'd0;
    case (state_q)
      LOAD:    usr_s = 2'd3;
      SHIFT:   usr_s = shift_en ? (dir_q ? 2'd2 : 2'd1) : 2'd0;
      default: usr_s = 2'd0;
    endcase
  end

  // cmd_ready drops the instant reset asserts, not only on the next edge
  assign bus.cmd_ready = reset_n & (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign usr_pi        = data_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_usr_seq.sv
// Bench for usr_seq driving a behavioural universal shift register; response
// words are checked against a scoreboard filled when commands are issued.
module tb_usr_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         shift_en = 1'b0;
  logic         abort = 1'b0;
  logic [1:0]   usr_s;
  logic [W-1:0] usr_pi, usr_po, sr;
  logic         busy;
  logic [W-1:0] ser_bits = '0;
  logic [1:0]   nidx = 2'd0;
  logic         sri, sli;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb_q[$];

  usr_seq_if #(.WIDTH(W)) cif();

  usr_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(cif.slave), .shift_en(shift_en),
    .abort(abort), .usr_s(usr_s), .usr_pi(usr_pi), .usr_po(usr_po), .busy(busy)
  );

  always #5 clk = ~clk;

  // universal shift register: right = toward bit 0, left = toward MSB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sr <= '0;
    else case (usr_s)
      2'd1: sr <= {sri, sr[W-1:1]};
      2'd2: sr <= {sr[W-2:0], sli};
      2'd3: sr <= usr_pi;
      default: sr <= sr;
    endcase
  end
  assign usr_po = sr;

  always @(posedge clk) begin
    if (cif.cmd_valid && cif.cmd_ready) nidx <= 2'd0;
    else if (usr_s == 2'd1 || usr_s == 2'd2) nidx <= nidx + 2'd1;
  end
  assign sri = ser_bits[nidx];
  assign sli = ser_bits[nidx];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && cif.rsp_valid && cif.rsp_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_rsp", 32'd1, 32'd0);
      else chk("sb_rsp_data", 32'(cif.rsp_data), 32'(sb_q.pop_front()));
    end
  end

  typedef struct packed {
    logic         op;
    logic         dir;
    logic [W-1:0] data;
    logic [W-1:0] bits;
    logic         tgl;
    logic [W-1:0] rsp;
    logic [W-1:0] out;
    logic [7:0]   lat;
  } vec_t;

  vec_t  vt[5];
  string vs[5];

  // called at posedge+1; returns at accept edge + 1
  task automatic start_cmd(input logic op, input logic dir, input logic [W-1:0] data,
                           input bit push, input logic [W-1:0] exp);
    cif.cmd_op    = op;
    cif.cmd_dir   = dir;
    cif.cmd_data  = data;
    cif.cmd_valid = 1'b1;
    @(negedge clk);
    chk("cmd_ready_idle", 32'(cif.cmd_ready), 32'd1);
    @(posedge clk); #1;
    cif.cmd_valid = 1'b0;
    if (push) sb_q.push_back(exp);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int lat, no;
    string got_s;
    logic [W-1:0] out;
    v = vt[i];
    ser_bits = v.bits;
    start_cmd(v.op, v.dir, v.data, 1'b1, v.rsp);
    shift_en = v.tgl ? 1'b0 : 1'b1;
    lat = -1; no = 0; got_s = ""; out = '0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      got_s = {got_s, $sformatf("%0d", usr_s)};
      if (k == 0 && !v.op) chk($sformatf("v%0d_usr_pi", i), 32'(usr_pi), 32'(v.data));
      if (usr_s == 2'd1 && no < W) begin out[no] = sr[0];   no++; end
      if (usr_s == 2'd2 && no < W) begin out[no] = sr[W-1]; no++; end
      if (cif.rsp_valid) begin lat = k; break; end
      @(posedge clk); #1;
      if (v.tgl) shift_en = ~shift_en;
    end
    chk($sformatf("v%0d_latency", i), 32'(lat), 32'(v.lat));
    chk_str($sformatf("v%0d_usr_s_seq", i), got_s, vs[i]);
    if (!v.op) chk($sformatf("v%0d_serial_out", i), 32'(out), 32'(v.out));
    @(posedge clk); #1;
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", i), 32'({cif.cmd_ready, cif.rsp_valid}), 32'b10);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    vt[0] = '{1'b0, 1'b0, 4'b1011, 4'b0000, 1'b0, 4'b0000, 4'b1011, 8'd6};  vs[0] = "3111100";
    vt[1] = '{1'b1, 1'b1, 4'b0000, 4'b1101, 1'b0, 4'b1011, 4'b0000, 8'd5};  vs[1] = "222200";
    vt[2] = '{1'b1, 1'b0, 4'b0000, 4'b0110, 1'b1, 4'b0110, 4'b0000, 8'd9};  vs[2] = "0101010100";
    vt[3] = '{1'b0, 1'b1, 4'b0110, 4'b1111, 1'b0, 4'b1111, 4'b0110, 8'd6};  vs[3] = "3222200";
    vt[4] = '{1'b0, 1'b0, 4'b1001, 4'b0001, 1'b1, 4'b0001, 4'b1001, 8'd9};  vs[4] = "3101010100";

    cif.cmd_valid = 1'b0; cif.cmd_op = 1'b0; cif.cmd_dir = 1'b0;
    cif.cmd_data = '0; cif.rsp_ready = 1'b1;
    #3;
    chk("rst_cmd_ready", 32'(cif.cmd_ready), 32'd0);
    chk("rst_usr_s",     32'(usr_s), 32'd0);
    chk("rst_usr_pi",    32'(usr_pi), 32'd0);
    chk("rst_rsp_valid", 32'(cif.rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(cif.rsp_data), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    #9 reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'({cif.cmd_ready, busy}), 32'b10);
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // backpressure: response held for 5 cycles, stray command ignored
    cif.rsp_ready = 1'b0;
    ser_bits = 4'b1111;
    start_cmd(1'b1, 1'b1, 4'b0000, 1'b1, 4'b1111);
    shift_en = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cif.rsp_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("bp_rsp_seen", 32'(seen), 32'd1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge clk);
      chk($sformatf("bp%0d_valid", j), 32'(cif.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", j),  32'(cif.rsp_data), 32'b1111);
      chk($sformatf("bp%0d_ready_s", j), 32'({cif.cmd_ready, usr_s}), 32'd0);
      @(posedge clk); #1;
      cif.cmd_valid = (j == 1);
    end
    cif.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_idle", 32'({busy, cif.rsp_valid, cif.cmd_ready}), 32'b001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_no_stray_cmd", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // abort on the second shift of a TX
    ser_bits = 4'b0000;
    start_cmd(1'b0, 1'b0, 4'b1010, 1'b0, 4'b0000);
    shift_en = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    chk("ab_second_shift", 32'(usr_s), 32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("ab_after", 32'({usr_s, cif.rsp_valid, cif.cmd_ready, busy}), 32'b00010);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk($sformatf("ab_no_rsp%0d", j), 32'(cif.rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    run_vec(0);

    // abort while a response is pending drops it
    cif.rsp_ready = 1'b0;
    ser_bits = 4'b1111;
    start_cmd(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (cif.rsp_valid) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    chk("abr_rsp_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    cif.rsp_ready = 1'b1;
    @(negedge clk);
    chk("abr_dropped", 32'({cif.rsp_valid, busy, cif.cmd_ready}), 32'b001);
    chk("abr_rsp_data_kept", 32'(cif.rsp_data), 32'b1111);
    @(posedge clk); #1;

    // asynchronous reset in the middle of SHIFT
    start_cmd(1'b1, 1'b0, 4'b0000, 1'b0, 4'b0000);
    @(posedge clk); #1;
    chk("rs_shifting", 32'(usr_s), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rs_immediate", 32'({usr_s, cif.rsp_valid, cif.cmd_ready, busy}), 32'd0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rs_release", 32'({cif.cmd_ready, busy, usr_s}), 32'b1000);
    chk("rs_rsp_data", 32'(cif.rsp_data), 32'd0);
    @(posedge clk); #1;
    run_vec(1);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
